// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: per-channel state encoding and a
// wrap-around index helper used by the consumer picker.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    CH_IDLE           = 3'd0,
    CH_READ_WAITING   = 3'd1,
    CH_WRITE_WAITING  = 3'd2,
    CH_READ_RELAYING  = 3'd3,
    CH_WRITE_RELAYING = 3'd4
  } ch_state_e;

  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Masked priority picker: first set request bit at or after start_i
// (wrapping), reported as one-hot grant, binary index and any-grant flag.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = wrap_idx(int'(start_i), k, N);
      if (!any_o && req_i[j]) begin
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel memory arbiter: each channel claims one requesting consumer
// and relays a single read or write. Define MEM_ARBITER_ROUND_ROBIN_EN for
// round-robin consumer search; otherwise lowest index wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  ch_state_e            state_q [NUM_CHANNELS];
  ch_state_e            state_d [NUM_CHANNELS];
  logic [CW-1:0]        owner_q [NUM_CHANNELS];
  logic [CW-1:0]        owner_d [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_d  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata_d [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rdata_d [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0]                    claimed;
  logic [NUM_CHANNELS:0][NUM_CONSUMERS-1:0]    avail;
  logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0]  grant;
  logic [NUM_CHANNELS-1:0][CW-1:0]             pick_idx;
  logic [NUM_CHANNELS-1:0]                     pick_any;
  logic [NUM_CHANNELS-1:0]                     take;
  logic [CW-1:0]                               start_idx;

  always_comb begin
    claimed = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (state_q[ch] != CH_IDLE) claimed[owner_q[ch]] = 1'b1;
    end
  end

  // Claims cascade: each channel only sees consumers left over by lower channels.
  assign avail[0] = (consumer_read_valid | consumer_write_valid) & ~claimed;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      rr_pick #(.N(NUM_CONSUMERS), .IW(CW)) u_pick (
        .req_i   (avail[gi]),
        .start_i (start_idx),
        .grant_o (grant[gi]),
        .idx_o   (pick_idx[gi]),
        .any_o   (pick_any[gi])
      );
      assign take[gi]      = pick_any[gi] && (state_q[gi] == CH_IDLE);
      assign avail[gi + 1] = take[gi] ? (avail[gi] & ~grant[gi]) : avail[gi];
    end
  endgenerate

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic [CW-1:0] ptr_q, ptr_d;

  assign start_idx = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (take[ch]) begin
        ptr_d = (pick_idx[ch] == CW'(NUM_CONSUMERS - 1)) ? '0 : pick_idx[ch] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  assign start_idx = '0;
`endif

  always_comb begin
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_d[ch] = state_q[ch];
      owner_d[ch] = owner_q[ch];
      addr_d[ch]  = addr_q[ch];
      wdata_d[ch] = wdata_q[ch];
      rdata_d[ch] = rdata_q[ch];
      case (state_q[ch])
        CH_IDLE: begin
          if (take[ch]) begin
            owner_d[ch] = pick_idx[ch];
            if (consumer_read_valid[pick_idx[ch]]) begin
              state_d[ch] = CH_READ_WAITING;
              addr_d[ch]  = consumer_read_address[pick_idx[ch]];
            end else begin
              state_d[ch] = CH_WRITE_WAITING;
              addr_d[ch]  = consumer_write_address[pick_idx[ch]];
              wdata_d[ch] = consumer_write_data[pick_idx[ch]];
            end
          end
        end
        CH_READ_WAITING: begin
          if (mem_read_ready[ch]) begin
            state_d[ch] = CH_READ_RELAYING;
            rdata_d[ch] = mem_read_data[ch];
          end
        end
        CH_WRITE_WAITING: begin
          if (mem_write_ready[ch]) state_d[ch] = CH_WRITE_RELAYING;
        end
        CH_READ_RELAYING: begin
          if (!consumer_read_valid[owner_q[ch]]) state_d[ch] = CH_IDLE;
        end
        CH_WRITE_RELAYING: begin
          if (!consumer_write_valid[owner_q[ch]]) state_d[ch] = CH_IDLE;
        end
        default: state_d[ch] = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= CH_IDLE;
        owner_q[ch] <= '0;
        addr_q[ch]  <= '0;
        wdata_q[ch] <= '0;
        rdata_q[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= state_d[ch];
        owner_q[ch] <= owner_d[ch];
        addr_q[ch]  <= addr_d[ch];
        wdata_q[ch] <= wdata_d[ch];
        rdata_q[ch] <= rdata_d[ch];
      end
    end
  end

  always_comb begin
    consumer_read_ready  = '0;
    consumer_read_data   = '0;
    consumer_write_ready = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      mem_read_valid[ch]    = (state_q[ch] == CH_READ_WAITING);
      mem_read_address[ch]  = addr_q[ch];
      mem_write_valid[ch]   = (state_q[ch] == CH_WRITE_WAITING);
      mem_write_address[ch] = addr_q[ch];
      mem_write_data[ch]    = wdata_q[ch];
      if (state_q[ch] == CH_READ_RELAYING) begin
        consumer_read_ready[owner_q[ch]] = 1'b1;
        consumer_read_data[owner_q[ch]]  = rdata_q[ch];
      end
      if (state_q[ch] == CH_WRITE_RELAYING) consumer_write_ready[owner_q[ch]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 1-channel and a 2-channel instance, each backed by
// a memory model that answers one cycle after it sees a request.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 1-channel instance
  logic [3:0]      c_rv1 = '0, c_wv1 = '0;
  logic [3:0][7:0] c_ra1 = '0, c_wa1 = '0, c_wd1 = '0;
  logic [3:0]      c_rr1, c_wr1;
  logic [3:0][7:0] c_rd1;
  logic [0:0]      m1_rv, m1_rr, m1_wv, m1_wr;
  logic [0:0][7:0] m1_ra, m1_rd, m1_wa, m1_wd;

  // 2-channel instance (reads only)
  logic [3:0]      c_rv2 = '0;
  logic [3:0][7:0] c_ra2 = '0;
  logic [3:0]      c_rr2, c_wr2;
  logic [3:0][7:0] c_rd2;
  logic [3:0]      c_wv2 = '0;
  logic [3:0][7:0] c_wa2 = '0, c_wd2 = '0;
  logic [1:0]      m2_rv, m2_rr, m2_wv;
  logic [1:0][7:0] m2_ra, m2_rd, m2_wa, m2_wd;
  logic [1:0]      m2_wr = '0;

  mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) dut1 (
    .clk(clk), .reset(rst),
    .consumer_read_valid(c_rv1), .consumer_read_address(c_ra1),
    .consumer_read_ready(c_rr1), .consumer_read_data(c_rd1),
    .consumer_write_valid(c_wv1), .consumer_write_address(c_wa1),
    .consumer_write_data(c_wd1), .consumer_write_ready(c_wr1),
    .mem_read_valid(m1_rv), .mem_read_address(m1_ra),
    .mem_read_ready(m1_rr), .mem_read_data(m1_rd),
    .mem_write_valid(m1_wv), .mem_write_address(m1_wa),
    .mem_write_data(m1_wd), .mem_write_ready(m1_wr)
  );

  mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) dut2 (
    .clk(clk), .reset(rst),
    .consumer_read_valid(c_rv2), .consumer_read_address(c_ra2),
    .consumer_read_ready(c_rr2), .consumer_read_data(c_rd2),
    .consumer_write_valid(c_wv2), .consumer_write_address(c_wa2),
    .consumer_write_data(c_wd2), .consumer_write_ready(c_wr2),
    .mem_read_valid(m2_rv), .mem_read_address(m2_ra),
    .mem_read_ready(m2_rr), .mem_read_data(m2_rd),
    .mem_write_valid(m2_wv), .mem_write_address(m2_wa),
    .mem_write_data(m2_wd), .mem_write_ready(m2_wr)
  );

  // Memory model: contents preset to addr ^ 0x33, with 0x10 holding 0xA5.
  logic [7:0] mem [256];
  logic [7:0] last_wa, last_wd;
  bit         stall = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h33;
      mem[8'h10] <= 8'hA5;
      m1_rr <= '0; m1_wr <= '0; m1_rd <= '0; m2_rr <= '0; m2_rd <= '0;
      last_wa <= '0; last_wd <= '0;
    end else begin
      m1_rr[0] <= m1_rv[0] && !m1_rr[0] && !stall;
      if (m1_rv[0] && !m1_rr[0] && !stall) m1_rd[0] <= mem[m1_ra[0]];
      m1_wr[0] <= m1_wv[0] && !m1_wr[0] && !stall;
      if (m1_wv[0] && !m1_wr[0] && !stall) begin
        mem[m1_wa[0]] <= m1_wd[0];
        last_wa <= m1_wa[0];
        last_wd <= m1_wd[0];
      end
      for (int ch = 0; ch < 2; ch++) begin
        m2_rr[ch] <= m2_rv[ch] && !m2_rr[ch];
        if (m2_rv[ch] && !m2_rr[ch]) m2_rd[ch] <= mem[m2_ra[ch]];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { int cons; logic [7:0] data; } exp_t;
  exp_t sb[$];

  typedef struct { int cons; bit wr; logic [7:0] addr; logic [7:0] data; } vec_t;
  vec_t vt[6];

  // Single transaction on dut1; data is write data or expected read data.
  task automatic do_txn(input int c, input bit wr, input logic [7:0] a, input logic [7:0] d);
    int lat;
    bit got;
    exp_t e;
    @(negedge clk);
    if (wr) begin c_wv1[c] = 1'b1; c_wa1[c] = a; c_wd1[c] = d; end
    else    begin c_rv1[c] = 1'b1; c_ra1[c] = a; end
    sb.push_back('{c, d});
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("mem_valid_issue", wr ? m1_wv[0] : m1_rv[0], 1);
        check("mem_addr", wr ? m1_wa[0] : m1_ra[0], a);
        if (wr) check("mem_wdata", m1_wd[0], d);
      end
      got = wr ? c_wr1[c] : c_rr1[c];
    end
    check("latency", lat, 3);
    e = sb.pop_front();
    if (wr) begin
      check("wr_addr", last_wa, a);
      check("wr_data", last_wd, e.data);
    end else begin
      check("rd_data", c_rd1[c], e.data);
    end
    check("mem_valid_drop", m1_rv[0] | m1_wv[0], 0);
    c_rv1[c] = 1'b0; c_wv1[c] = 1'b0;
    @(negedge clk);
    check("ready_drop", c_rr1[c] | c_wr1[c], 0);
    $display("txn cons=%0d wr=%0d addr=%02h data=%02h latency=%0d", c, wr, a, d, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, served, w;
    bit rer;
    int cnt2 [4];

    vt[0] = '{2, 1'b0, 8'h10, 8'hA5};
    vt[1] = '{1, 1'b1, 8'h20, 8'h3C};
    vt[2] = '{0, 1'b0, 8'h20, 8'h3C};
    vt[3] = '{3, 1'b0, 8'hFF, 8'hCC};
    vt[4] = '{3, 1'b1, 8'h00, 8'hFF};
    vt[5] = '{0, 1'b0, 8'h00, 8'hFF};

    repeat (3) @(negedge clk);
    check("rst_mem_rv", {m1_rv, m2_rv}, 0);
    check("rst_mem_addr", {m1_ra[0], m2_ra}, 0);
    check("rst_cons_ready", {c_rr1, c_wr1, c_rr2}, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) do_txn(vt[i].cons, vt[i].wr, vt[i].addr, vt[i].data);

    // Read wins over write for the same consumer; ready held while valid held.
    @(negedge clk);
    c_rv1[1] = 1'b1; c_ra1[1] = 8'h07;
    c_wv1[1] = 1'b1; c_wa1[1] = 8'h08; c_wd1[1] = 8'h99;
    @(negedge clk);
    check("rbw_read_first", {m1_rv[0], m1_wv[0]}, 2'b10);
    w = 0;
    while (!c_rr1[1] && w < 20) begin @(negedge clk); w++; end
    check("rbw_read_data", c_rd1[1], 8'h34);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_ready", c_rr1[1], 1);
      check("hold_no_mem_req", {m1_rv[0], m1_wv[0]}, 0);
    end
    c_rv1[1] = 1'b0;
    @(negedge clk);
    check("hold_ready_drop", c_rr1[1], 0);
    w = 0;
    while (!c_wr1[1] && w < 20) begin @(negedge clk); w++; end
    check("rbw_write_done", c_wr1[1], 1);
    check("rbw_write_addr", last_wa, 8'h08);
    check("rbw_write_data", last_wd, 8'h99);
    c_wv1[1] = 1'b0;
    $display("txn cons=1 read 07 then write 08<=99 with 5-cycle hold");
    repeat (2) @(negedge clk);

    // Contention on one channel; consumer 0 re-requests right after each service.
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    for (int c = 0; c < 4; c++) sb.push_back('{c, 8'h50 + 8'(c)});
`else
    for (int c = 0; c < 4; c++) sb.push_back('{0, 8'h50});
`endif
    @(negedge clk);
    for (int c = 0; c < 4; c++) c_ra1[c] = 8'h50 + 8'(c);
    c_rv1 = 4'hF;
    served = 0; n = 0; rer = 1'b0;
    while (served < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (rer) begin c_rv1[0] = 1'b1; rer = 1'b0; end
      for (int c = 0; c < 4; c++) begin
        if (c_rr1[c] && sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("contend_order", c, e.cons);
          check("contend_data", c_rd1[c], (8'h50 + 8'(c)) ^ 8'h33);
          $display("txn contention served consumer %0d", c);
          c_rv1[c] = 1'b0;
          if (c == 0) rer = 1'b1;
          served++;
        end
      end
    end
    check("contend_served", served, 4);
    c_rv1 = '0;
    sb.delete();
    repeat (8) @(negedge clk);

    // Two channels, four simultaneous reads.
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin c_ra2[c] = 8'h40 + 8'(c); cnt2[c] = 0; end
    c_rv2 = 4'hF;
    @(negedge clk);
    check("dual_both_valid", m2_rv, 2'b11);
    check("dual_ch0_addr", m2_ra[0], 8'h40);
    check("dual_ch1_addr", m2_ra[1], 8'h41);
    served = 0; n = 0;
    while (served < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (m2_rv == 2'b11) check("dual_distinct", m2_ra[0] != m2_ra[1], 1);
      for (int c = 0; c < 4; c++) begin
        if (c_rr2[c]) begin
          check("dual_data", c_rd2[c], (8'h40 + 8'(c)) ^ 8'h33);
          $display("txn dual-channel served consumer %0d", c);
          cnt2[c]++;
          c_rv2[c] = 1'b0;
          served++;
        end
      end
    end
    for (int c = 0; c < 4; c++) check("dual_served_once", cnt2[c], 1);
    repeat (3) @(negedge clk);

    // Reset during a stalled read.
    stall = 1'b1;
    c_rv1[2] = 1'b1; c_ra1[2] = 8'h10;
    repeat (3) @(negedge clk);
    check("stall_waiting", m1_rv[0], 1);
    check("stall_addr", m1_ra[0], 8'h10);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {m1_rv, m1_wv}, 0);
    check("async_rst_addr", m1_ra[0], 0);
    check("async_rst_ready", {c_rr1, c_rd1}, 0);
    c_rv1 = '0;
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    $display("txn reset during stalled read of 10");
    do_txn(2, 1'b0, 8'h10, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
